// File: rtl/dot_prod_lag_sched.sv
// Lag-sweep sequencer for CAF search: drives one dot_prod per lag, streams
// {lag, i, q} downstream and tracks the peak |i|+|q| and the lag where it occurred.
module dot_prod_lag_sched #(
  parameter  int unsigned i_bits         = 24,
  parameter  int unsigned q_bits         = 24,
  parameter  int unsigned lag_bits       = 8,
  parameter  int unsigned timeout_cycles = 64,
  localparam int unsigned mag_bits       = ((i_bits > q_bits) ? i_bits : q_bits) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [lag_bits-1:0]        num_lags,
  output logic                       busy,
  output logic                       done,
  output logic                       error,
  output logic [lag_bits-1:0]        y_shift,
  output logic                       dp_tvalid,
  output logic                       dp_tready,
  input  logic                       dp_result_valid,
  input  logic signed [i_bits-1:0]   dp_i,
  input  logic signed [q_bits-1:0]   dp_q,
  output logic                       s_axis_lag_tvalid,
  input  logic                       s_axis_lag_tready,
  output logic [lag_bits-1:0]        lag_index,
  output logic signed [i_bits-1:0]   lag_i,
  output logic signed [q_bits-1:0]   lag_q,
  output logic [mag_bits-1:0]        peak_mag,
  output logic [lag_bits-1:0]        peak_lag
);

  localparam int unsigned wait_bits = (timeout_cycles > 2) ? $clog2(timeout_cycles) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT,
    DONE
  } state_t;

  state_t                     state, state_n;
  logic [lag_bits-1:0]        lag, lag_n;
  logic [lag_bits-1:0]        num_lags_q, num_lags_n;
  logic [wait_bits-1:0]       wait_cnt, wait_cnt_n;
  logic [lag_bits-1:0]        y_shift_n, lag_index_n, peak_lag_n;
  logic signed [i_bits-1:0]   lag_i_n;
  logic signed [q_bits-1:0]   lag_q_n;
  logic [mag_bits-1:0]        peak_mag_n;
  logic                       error_n, busy_n, done_n, dp_tvalid_n, dp_tready_n, lag_tvalid_n;

  logic [mag_bits-1:0]        ext_i_c, ext_q_c, abs_i_c, abs_q_c, mag_c;

  // Magnitude of the held result; one extra bit keeps |most-negative| and the sum exact.
  always_comb begin
    ext_i_c = {{(mag_bits - i_bits){lag_i[i_bits-1]}}, lag_i};
    ext_q_c = {{(mag_bits - q_bits){lag_q[q_bits-1]}}, lag_q};
    abs_i_c = ext_i_c[mag_bits-1] ? (mag_bits'(0) - ext_i_c) : ext_i_c;
    abs_q_c = ext_q_c[mag_bits-1] ? (mag_bits'(0) - ext_q_c) : ext_q_c;
    mag_c   = abs_i_c + abs_q_c;
  end

  // Next-state and next-register values; flag outputs are decoded from the next state.
  always_comb begin
    state_n     = state;
    lag_n       = lag;
    num_lags_n  = num_lags_q;
    wait_cnt_n  = wait_cnt;
    y_shift_n   = y_shift;
    lag_index_n = lag_index;
    lag_i_n     = lag_i;
    lag_q_n     = lag_q;
    peak_mag_n  = peak_mag;
    peak_lag_n  = peak_lag;
    error_n     = error;

    case (state)
      IDLE: begin
        if (start) begin
          error_n = 1'b0;
          if (num_lags != '0) begin
            state_n    = ISSUE;
            num_lags_n = num_lags;
            lag_n      = '0;
            y_shift_n  = '0;
            peak_mag_n = '0;
            peak_lag_n = '0;
          end else begin
            state_n = DONE;
          end
        end
      end
      ISSUE: begin
        state_n    = WAIT;
        wait_cnt_n = '0;
      end
      WAIT: begin
        if (dp_result_valid) begin
          state_n     = EMIT;
          lag_i_n     = dp_i;
          lag_q_n     = dp_q;
          lag_index_n = lag;
        end else if (wait_cnt == wait_bits'(timeout_cycles - 1)) begin
          state_n = DONE;
          error_n = 1'b1;
        end else begin
          wait_cnt_n = wait_cnt + wait_bits'(1);
        end
      end
      EMIT: begin
        if (s_axis_lag_tready) begin
          // Strict compare: ties keep the earliest lag.
          if (mag_c > peak_mag) begin
            peak_mag_n = mag_c;
            peak_lag_n = lag;
          end
          if (lag == num_lags_q - lag_bits'(1)) begin
            state_n = DONE;
          end else begin
            state_n   = ISSUE;
            lag_n     = lag + lag_bits'(1);
            y_shift_n = lag + lag_bits'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n       = (state_n != IDLE);
    done_n       = (state_n == DONE);
    dp_tvalid_n  = (state_n == ISSUE);
    dp_tready_n  = (state_n == ISSUE) || (state_n == WAIT);
    lag_tvalid_n = (state_n == EMIT);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      lag               <= '0;
      num_lags_q        <= '0;
      wait_cnt          <= '0;
      y_shift           <= '0;
      lag_index         <= '0;
      lag_i             <= '0;
      lag_q             <= '0;
      peak_mag          <= '0;
      peak_lag          <= '0;
      error             <= 1'b0;
      busy              <= 1'b0;
      done              <= 1'b0;
      dp_tvalid         <= 1'b0;
      dp_tready         <= 1'b0;
      s_axis_lag_tvalid <= 1'b0;
    end else begin
      state             <= state_n;
      lag               <= lag_n;
      num_lags_q        <= num_lags_n;
      wait_cnt          <= wait_cnt_n;
      y_shift           <= y_shift_n;
      lag_index         <= lag_index_n;
      lag_i             <= lag_i_n;
      lag_q             <= lag_q_n;
      peak_mag          <= peak_mag_n;
      peak_lag          <= peak_lag_n;
      error             <= error_n;
      busy              <= busy_n;
      done              <= done_n;
      dp_tvalid         <= dp_tvalid_n;
      dp_tready         <= dp_tready_n;
      s_axis_lag_tvalid <= lag_tvalid_n;
    end
  end

endmodule

// File: tb/tb_dot_prod_lag_sched.sv
// Bench for dot_prod_lag_sched: a dot_prod responder model drives results from
// per-lag tables, and a plain-arithmetic reference derives the expected stream and peak.
module tb_dot_prod_lag_sched;

  localparam int unsigned IB = 24;
  localparam int unsigned QB = 24;
  localparam int unsigned LB = 8;
  localparam int unsigned MB = 25;

  logic                 clk = 1'b0;
  logic                 reset, start;
  logic [LB-1:0]        num_lags;
  logic                 busy, done, error, dp_tvalid, dp_tready;
  logic [LB-1:0]        y_shift, lag_index, peak_lag;
  logic                 dp_result_valid, s_axis_lag_tvalid, s_axis_lag_tready;
  logic signed [IB-1:0] dp_i, lag_i;
  logic signed [QB-1:0] dp_q, lag_q;
  logic [MB-1:0]        peak_mag;

  dot_prod_lag_sched dut (
    .clk(clk), .reset(reset), .start(start), .num_lags(num_lags),
    .busy(busy), .done(done), .error(error), .y_shift(y_shift),
    .dp_tvalid(dp_tvalid), .dp_tready(dp_tready), .dp_result_valid(dp_result_valid),
    .dp_i(dp_i), .dp_q(dp_q), .s_axis_lag_tvalid(s_axis_lag_tvalid),
    .s_axis_lag_tready(s_axis_lag_tready), .lag_index(lag_index), .lag_i(lag_i),
    .lag_q(lag_q), .peak_mag(peak_mag), .peak_lag(peak_lag)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Responder configuration and per-lag result tables
  logic signed [IB-1:0] ri [256];
  logic signed [QB-1:0] rq [256];
  int lat = 2;
  bit no_resp = 1'b0;
  bit rand_ready = 1'b0;
  int stall_lag = 0;
  int stall_len = 0;

  // dot_prod responder and downstream ready driver
  int cd = 0;
  int stalled = 0;
  logic [LB-1:0] pend = '0;
  always @(posedge clk) begin
    #1;
    dp_result_valid = 1'b0;
    dp_i = IB'($urandom);
    dp_q = QB'($urandom);
    if (reset) cd = 0;
    else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dp_result_valid = 1'b1;
          dp_i = ri[pend];
          dp_q = rq[pend];
        end
      end
      if (dp_tvalid && !no_resp) begin
        cd = lat;
        pend = y_shift;
      end
    end
    s_axis_lag_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!busy) stalled = 0;
    else if (s_axis_lag_tvalid && lag_index == LB'(stall_lag) && stalled < stall_len) begin
      s_axis_lag_tready = 1'b0;
      stalled++;
    end
  end

  // Observations from the last sweep
  logic [LB-1:0]        q_lag [$];
  logic signed [IB-1:0] q_i [$];
  logic signed [QB-1:0] q_q [$];
  int n_tvalid, done_cyc, first_tv, hold_viol, shift_viol, stall_seen;
  bit done_len_ok;

  task automatic run_sweep(input int n, input int budget);
    bit prev_stall;
    logic [LB-1:0] pl;
    logic signed [IB-1:0] pi;
    logic signed [QB-1:0] pq;
    q_lag.delete(); q_i.delete(); q_q.delete();
    n_tvalid = 0; done_cyc = -1; first_tv = -1; hold_viol = 0; shift_viol = 0;
    stall_seen = 0; done_len_ok = 1'b0; prev_stall = 1'b0;
    pl = '0; pi = '0; pq = '0;
    @(posedge clk); #1; start = 1'b1; num_lags = LB'(n);
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (dp_tvalid) begin
        if (first_tv < 0) first_tv = k;
        if (y_shift !== LB'(n_tvalid)) shift_viol++;
        n_tvalid++;
      end
      if (s_axis_lag_tvalid && lag_index !== y_shift) shift_viol++;
      if (prev_stall && (!s_axis_lag_tvalid || lag_index !== pl || lag_i !== pi ||
                         lag_q !== pq || dp_tvalid)) hold_viol++;
      if (s_axis_lag_tvalid && s_axis_lag_tready) begin
        q_lag.push_back(lag_index); q_i.push_back(lag_i); q_q.push_back(lag_q);
      end
      prev_stall = s_axis_lag_tvalid && !s_axis_lag_tready;
      if (prev_stall) stall_seen++;
      pl = lag_index; pi = lag_i; pq = lag_q;
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    if (done_cyc > 0) begin
      @(negedge clk);
      done_len_ok = !done && !busy;
    end
  endtask

  // Reference: results arrive in lag order straight from the tables
  function automatic int stream_errs(input int n);
    int e;
    e = (q_lag.size() != n) ? 1 : 0;
    for (int k = 0; k < n && k < q_lag.size(); k++)
      if (q_lag[k] !== LB'(k) || q_i[k] !== ri[k] || q_q[k] !== rq[k]) e++;
    return e;
  endfunction

  // Reference: peak of |i|+|q| over the sweep, earliest lag wins ties
  task automatic ref_peak(input int n, output longint pm, output int pl);
    longint a, b;
    pm = 0; pl = 0;
    for (int k = 0; k < n; k++) begin
      a = ri[k]; b = rq[k];
      if (a < 0) a = -a;
      if (b < 0) b = -b;
      if (a + b > pm) begin
        pm = a + b;
        pl = k;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++;
    if ({busy, done, error, y_shift, dp_tvalid, dp_tready, s_axis_lag_tvalid,
         lag_index, lag_i, lag_q, peak_mag, peak_lag} !== '0) begin
      n_err++; $display("FAIL reset_outputs: got nonzero outputs busy=%0b peak_mag=%0d expected all 0", busy, peak_mag);
    end
  endtask

  task automatic test_basic();
    longint pm; int pl;
    lat = 2;
    for (int k = 0; k < 4; k++) begin ri[k] = IB'(k); rq[k] = QB'(-k); end
    run_sweep(4, 200);
    ref_peak(4, pm, pl);
    n_chk++; if (stream_errs(4) !== 0) begin n_err++; $display("FAIL basic_stream: got %0d bad entries expected 0", stream_errs(4)); end
    n_chk++; if (peak_mag !== MB'(6) || peak_mag !== MB'(pm)) begin n_err++; $display("FAIL basic_peak_mag: got %0d expected 6", peak_mag); end
    n_chk++; if (peak_lag !== LB'(3)) begin n_err++; $display("FAIL basic_peak_lag: got %0d expected 3", peak_lag); end
    n_chk++; if (n_tvalid !== 4) begin n_err++; $display("FAIL basic_tvalid_count: got %0d expected 4", n_tvalid); end
    n_chk++; if (first_tv !== 1) begin n_err++; $display("FAIL basic_first_tvalid: got %0d expected 1", first_tv); end
    n_chk++; if (done_cyc !== 17) begin n_err++; $display("FAIL basic_done_cycle: got %0d expected 17", done_cyc); end
    n_chk++; if (!done_len_ok) begin n_err++; $display("FAIL basic_done_pulse: got long pulse or busy expected 1-cycle done"); end
    n_chk++; if (shift_viol !== 0) begin n_err++; $display("FAIL basic_y_shift: got %0d violations expected 0", shift_viol); end
    n_chk++; if (lag_i !== IB'(3) || lag_q !== QB'(-3) || error !== 1'b0) begin
      n_err++; $display("FAIL basic_hold: got i=%0d q=%0d err=%0b expected 3 -3 0", lag_i, lag_q, error); end
  endtask

  task automatic test_peak_tie();
    ri[0] = 2;  rq[0] = -3;
    ri[1] = -4; rq[1] = 5;
    ri[2] = 9;  rq[2] = 0;
    ri[3] = 0;  rq[3] = -2;
    run_sweep(4, 200);
    n_chk++; if (peak_mag !== MB'(9)) begin n_err++; $display("FAIL tie_peak_mag: got %0d expected 9", peak_mag); end
    n_chk++; if (peak_lag !== LB'(1)) begin n_err++; $display("FAIL tie_peak_lag: got %0d expected 1", peak_lag); end
  endtask

  task automatic test_most_negative();
    ri[0] = {1'b1, {(IB-1){1'b0}}};
    rq[0] = {1'b1, {(QB-1){1'b0}}};
    run_sweep(1, 50);
    n_chk++; if (peak_mag !== MB'(1) << IB) begin n_err++; $display("FAIL mostneg_peak_mag: got %0d expected %0d", peak_mag, 1 << IB); end
    n_chk++; if (stream_errs(1) !== 0 || peak_lag !== '0) begin n_err++; $display("FAIL mostneg_stream: got %0d bad lag=%0d expected 0 0", stream_errs(1), peak_lag); end
  endtask

  task automatic test_backpressure();
    for (int k = 0; k < 4; k++) begin ri[k] = IB'($urandom); rq[k] = QB'($urandom); end
    stall_lag = 1; stall_len = 5;
    run_sweep(4, 300);
    stall_len = 0;
    n_chk++; if (stall_seen !== 5) begin n_err++; $display("FAIL bp_stall_cycles: got %0d expected 5", stall_seen); end
    n_chk++; if (hold_viol !== 0) begin n_err++; $display("FAIL bp_hold_stable: got %0d violations expected 0", hold_viol); end
    n_chk++; if (n_tvalid !== 4 || stream_errs(4) !== 0) begin n_err++; $display("FAIL bp_stream: got tvalid=%0d bad=%0d expected 4 0", n_tvalid, stream_errs(4)); end
    n_chk++; if (done_cyc !== 22) begin n_err++; $display("FAIL bp_done_cycle: got %0d expected 22", done_cyc); end
  endtask

  task automatic test_timeout();
    no_resp = 1'b1;
    run_sweep(3, 200);
    no_resp = 1'b0;
    n_chk++; if (done_cyc !== 66) begin n_err++; $display("FAIL timeout_done_cycle: got %0d expected 66", done_cyc); end
    n_chk++; if (error !== 1'b1 || busy !== 1'b0) begin n_err++; $display("FAIL timeout_error: got err=%0b busy=%0b expected 1 0", error, busy); end
    n_chk++; if (n_tvalid !== 1 || q_lag.size() !== 0) begin n_err++; $display("FAIL timeout_traffic: got tvalid=%0d results=%0d expected 1 0", n_tvalid, q_lag.size()); end
  endtask

  task automatic test_zero_lags();
    run_sweep(0, 20);
    n_chk++; if (done_cyc !== 1 || !done_len_ok) begin n_err++; $display("FAIL zero_done: got cycle=%0d ok=%0b expected 1 1", done_cyc, done_len_ok); end
    n_chk++; if (n_tvalid !== 0) begin n_err++; $display("FAIL zero_tvalid: got %0d expected 0", n_tvalid); end
    n_chk++; if (error !== 1'b0) begin n_err++; $display("FAIL zero_error_clear: got %0b expected 0", error); end
  endtask

  task automatic test_reset_midsweep();
    bit found;
    found = 1'b0;
    lat = 2;
    for (int k = 0; k < 4; k++) begin ri[k] = IB'(k); rq[k] = QB'(-k); end
    @(posedge clk); #1; start = 1'b1; num_lags = LB'(4);
    @(posedge clk); #1; start = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (dp_tvalid && y_shift == LB'(2)) found = 1'b1;
    end
    n_chk++; if (!found) begin n_err++; $display("FAIL midreset_reach_lag2: got no lag 2 issue expected one"); end
    @(posedge clk); #1; reset = 1'b1; #1;
    n_chk++;
    if ({busy, done, error, y_shift, dp_tvalid, dp_tready, s_axis_lag_tvalid,
         lag_index, lag_i, lag_q, peak_mag, peak_lag} !== '0) begin
      n_err++; $display("FAIL midreset_outputs: got busy=%0b tready=%0b y_shift=%0d expected all 0", busy, dp_tready, y_shift);
    end
    @(posedge clk); #1; reset = 1'b0;
    run_sweep(4, 200);
    n_chk++; if (stream_errs(4) !== 0 || first_tv !== 1 || done_cyc !== 17) begin
      n_err++; $display("FAIL midreset_fresh_sweep: got bad=%0d first=%0d done=%0d expected 0 1 17", stream_errs(4), first_tv, done_cyc); end
    n_chk++; if (peak_mag !== MB'(6) || peak_lag !== LB'(3)) begin n_err++; $display("FAIL midreset_peak: got %0d@%0d expected 6@3", peak_mag, peak_lag); end
  endtask

  task automatic test_random();
    longint pm; int pl; int n; int sel;
    rand_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      n = $urandom_range(1, 12);
      lat = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        sel = $urandom_range(0, 7);
        ri[k] = (sel == 0) ? {1'b1, {(IB-1){1'b0}}} : (sel == 1) ? '0 : IB'($urandom);
        rq[k] = (sel == 2) ? {1'b1, {(QB-1){1'b0}}} : (sel == 3) ? '0 : QB'($urandom);
      end
      run_sweep(n, 2000);
      ref_peak(n, pm, pl);
      n_chk++; if (stream_errs(n) !== 0 || hold_viol !== 0) begin n_err++; $display("FAIL rand_stream[%0d]: got bad=%0d hold=%0d expected 0 0", s, stream_errs(n), hold_viol); end
      n_chk++; if (peak_mag !== MB'(pm)) begin n_err++; $display("FAIL rand_peak_mag[%0d]: got %0d expected %0d", s, peak_mag, pm); end
      n_chk++; if (peak_lag !== LB'(pl)) begin n_err++; $display("FAIL rand_peak_lag[%0d]: got %0d expected %0d", s, peak_lag, pl); end
      n_chk++; if (n_tvalid !== n || error !== 1'b0 || !done_len_ok) begin
        n_err++; $display("FAIL rand_control[%0d]: got tvalid=%0d err=%0b ok=%0b expected %0d 0 1", s, n_tvalid, error, done_len_ok, n); end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; num_lags = '0;
    repeat (3) @(posedge clk);
    test_reset();
    @(posedge clk); #1; reset = 1'b0;
    test_basic();
    test_peak_tie();
    test_most_negative();
    test_backpressure();
    test_timeout();
    test_zero_lags();
    test_reset_midsweep();
    test_random();
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
